// File: rtl/pack_pkg.sv
// rtl/pack_pkg.sv - shared framing constants and FSM state type for the Pack/Unpack pair
//
// Holds the packet geometry (payload bits, output word width), the sync word
// and its length, and the two-state receiver enum. The transmit-side Pack
// block uses the same definitions so both ends agree on framing.
package pack_pkg;

  localparam int SIZE_BIT_PACK = 1976;
  localparam int SIZE_OUTPUT_BIT = 8;
  localparam int SIZE_PREAMBLE = 32;
  localparam logic [31:0] PREAMBLE = 32'hCF80AA31;

  typedef enum logic {
    SEARCH  = 1'b0,
    RECEIVE = 1'b1
  } state_t;

  // Counter width that never collapses to zero bits for a count of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unpack_if.sv
// rtl/unpack_if.sv - serial-in / word-out handshake bundle for the unpack block
//
// Serial side : i_data, i_valid_input (driver -> unpack), o_ready (unpack -> driver)
// Word side   : o_data, o_valid, o_last (unpack -> sink), i_ready_output (sink -> unpack)
// Status      : o_sync, high while payload of a locked packet is being received
// slave modport is the unpack block; master modport is whatever drives and sinks it.
interface unpack_if #(
  parameter int SIZE_OUTPUT_BIT = pack_pkg::SIZE_OUTPUT_BIT
);

  logic                       i_data;
  logic                       i_valid_input;
  logic                       o_ready;
  logic [SIZE_OUTPUT_BIT-1:0] o_data;
  logic                       o_valid;
  logic                       i_ready_output;
  logic                       o_last;
  logic                       o_sync;

  modport slave (
    input  i_data, i_valid_input, i_ready_output,
    output o_ready, o_data, o_valid, o_last, o_sync
  );

  modport master (
    output i_data, i_valid_input, i_ready_output,
    input  o_ready, o_data, o_valid, o_last, o_sync
  );

endinterface

// File: rtl/preamble_detector.sv
// rtl/preamble_detector.sv - sliding sync-word window with clear and same-cycle match
//
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_shift          : a serial bit is consumed this cycle while searching
//   i_bit            : that serial bit (shifted into the window LSB)
//   i_clear          : zero the window (end of packet)
//   o_match          : window including this cycle's bit equals PREAMBLE
module preamble_detector #(
  parameter int                       SIZE_PREAMBLE = pack_pkg::SIZE_PREAMBLE,
  parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE      = pack_pkg::PREAMBLE
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_shift,
  input  logic i_bit,
  input  logic i_clear,
  output logic o_match
);

  logic [SIZE_PREAMBLE-1:0] window;
  logic [SIZE_PREAMBLE-1:0] window_next;

  assign window_next = {window[SIZE_PREAMBLE-2:0], i_bit};

  // Compare against the post-shift value so the match is seen on the cycle
  // the final preamble bit arrives, not one cycle later.
  assign o_match = i_shift && (window_next == PREAMBLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      window <= '0;
    end else if (i_clear) begin
      window <= '0;
    end else if (i_shift) begin
      window <= window_next;
    end
  end

endmodule

// File: rtl/unpack.sv
// rtl/unpack.sv - serial bitstream deframer: preamble lock, then MSB-first word assembly
//
// Ports:
//   i_clk     : clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : unpack_if.slave - serial input handshake, word output handshake,
//               o_last on the final word of a packet, o_sync while locked
// SEARCH hunts for PREAMBLE bit by bit; RECEIVE collects SIZE_BIT_PACK payload
// bits into SIZE_OUTPUT_BIT-bit words, then returns to SEARCH with a clean window.
module unpack #(
  parameter int                       SIZE_BIT_PACK   = pack_pkg::SIZE_BIT_PACK,
  parameter int                       SIZE_OUTPUT_BIT = pack_pkg::SIZE_OUTPUT_BIT,
  parameter int                       SIZE_PREAMBLE   = pack_pkg::SIZE_PREAMBLE,
  parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE        = pack_pkg::PREAMBLE
) (
  input  logic    i_clk,
  input  logic    i_reset_n,
  unpack_if.slave bus
);

  import pack_pkg::*;

  localparam int NUM_WORDS  = SIZE_BIT_PACK / SIZE_OUTPUT_BIT;
  localparam int BIT_CNT_W  = cnt_width(SIZE_OUTPUT_BIT);
  localparam int WORD_CNT_W = cnt_width(NUM_WORDS);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(SIZE_OUTPUT_BIT - 1);
  localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(NUM_WORDS - 1);

  state_t                     state;
  logic                       ready_en;
  logic [SIZE_OUTPUT_BIT-1:0] shreg;
  logic [SIZE_OUTPUT_BIT-1:0] word_next;
  logic [BIT_CNT_W-1:0]       bit_cnt;
  logic [WORD_CNT_W-1:0]      word_cnt;
  logic                       slot_free;
  logic                       stall;
  logic                       consume;
  logic                       out_xfer;
  logic                       word_done;
  logic                       last_done;
  logic                       match;

  // A slot being drained this very cycle counts as free, so the sink
  // accepting a word never costs an input bubble.
  assign slot_free = !bus.o_valid || bus.i_ready_output;
  assign stall     = (state == RECEIVE) && (bit_cnt == LAST_BIT) && !slot_free;

  // ready_en keeps o_ready low through reset and lets it rise on the
  // first edge afterwards.
  assign bus.o_ready = ready_en && !stall;

  assign consume   = bus.i_valid_input && bus.o_ready;
  assign out_xfer  = bus.o_valid && bus.i_ready_output;
  assign word_next = {shreg[SIZE_OUTPUT_BIT-2:0], bus.i_data};
  assign word_done = consume && (state == RECEIVE) && (bit_cnt == LAST_BIT);
  assign last_done = word_done && (word_cnt == LAST_WORD);

  // The window only moves while searching, so payload that happens to
  // contain the sync word cannot restart framing mid-packet.
  preamble_detector #(
    .SIZE_PREAMBLE(SIZE_PREAMBLE),
    .PREAMBLE     (PREAMBLE)
  ) u_detector (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_shift  (consume && (state == SEARCH)),
    .i_bit    (bus.i_data),
    .i_clear  (last_done),
    .o_match  (match)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= SEARCH;
      ready_en    <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      bus.o_data  <= '0;
      bus.o_valid <= 1'b0;
      bus.o_last  <= 1'b0;
      bus.o_sync  <= 1'b0;
    end else begin
      ready_en <= 1'b1;

      // Drain first; a load later in this block overrides it.
      if (out_xfer) begin
        bus.o_valid <= 1'b0;
        bus.o_last  <= 1'b0;
      end

      case (state)
        SEARCH: begin
          if (match) begin
            state      <= RECEIVE;
            bus.o_sync <= 1'b1;
            bit_cnt    <= '0;
            word_cnt   <= '0;
          end
        end
        RECEIVE: begin
          if (consume) begin
            shreg <= word_next;
            if (word_done) begin
              bit_cnt     <= '0;
              bus.o_data  <= word_next;
              bus.o_valid <= 1'b1;
              bus.o_last  <= last_done;
              if (last_done) begin
                state      <= SEARCH;
                bus.o_sync <= 1'b0;
                word_cnt   <= '0;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unpack.sv
// tb/tb_unpack.sv - randomized self-checking bench for unpack against a framing model
module tb_unpack;

  localparam int          W         = 8;
  localparam int          NBITS     = 1976;
  localparam int          NWORDS    = NBITS / W;
  localparam logic [31:0] PRE       = 32'hCF80AA31;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unpack_if #(.SIZE_OUTPUT_BIT(W)) bus ();

  unpack dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Stream model: every bit queued for sending carries the receiver role it
  // will meet (locked or not, completes a word or not); completed words are
  // queued as {last, data}.
  bit         q_bits[$];
  bit         q_sync[$];
  bit         q_done[$];
  logic [8:0] q_exp[$];
  bit          m_rx;
  logic [31:0] m_win;
  int          m_cnt;
  logic [7:0]  m_word;
  bit          g_full;
  int          pkt_words;
  int          n_pkts;
  int          stall_drops;

  task automatic model_clear();
    q_bits.delete(); q_sync.delete(); q_done.delete(); q_exp.delete();
    m_rx = 0; m_win = '0; m_cnt = 0; m_word = '0; g_full = 0; pkt_words = 0;
  endtask

  task automatic push_bit(input bit b);
    bit done;
    done = 0;
    q_bits.push_back(b);
    q_sync.push_back(m_rx);
    if (!m_rx) begin
      m_win = {m_win[30:0], b};
      if (m_win == PRE) begin
        m_rx = 1;
        m_cnt = 0;
      end
    end else begin
      m_word = {m_word[6:0], b};
      m_cnt++;
      if (m_cnt % W == 0) begin
        done = 1;
        q_exp.push_back({m_cnt == NBITS, m_word});
        if (m_cnt == NBITS) begin
          m_rx = 0;
          m_win = '0;
        end
      end
    end
    q_done.push_back(done);
  endtask

  task automatic push_word(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) push_bit(v[i]);
  endtask

  // kind 0: repeating 0x81, 1: random bytes, 2: random with the sync word at byte 10
  task automatic push_packet(input int kind);
    logic [31:0] pre_v;
    logic [7:0]  b;
    pre_v = PRE;
    push_word(PRE, 32);
    for (int w = 0; w < NWORDS; w++) begin
      if (kind == 0) b = 8'h81;
      else if (kind == 2 && w >= 10 && w <= 13) b = pre_v[31 - 8*(w-10) -: 8];
      else b = 8'($urandom);
      push_word({24'h0, b}, 8);
    end
  endtask

  // Enters at time 0 or on a negedge; leaves 1 time unit after a rising edge.
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    bus.i_valid_input = 1'b0;
    #1;
    check_eq("rst_o_data", bus.o_data, 0);
    check_eq("rst_o_valid", bus.o_valid, 0);
    check_eq("rst_o_last", bus.o_last, 0);
    check_eq("rst_o_sync", bus.o_sync, 0);
    check_eq("rst_o_ready", bus.o_ready, 0);
    for (int i = 0; i < cycles; i++) @(posedge clk);
    #1;
    check_eq("rst_hold_valid", bus.o_valid, 0);
    check_eq("rst_hold_ready", bus.o_ready, 0);
    rst_n = 1'b1;
    #1;
    check_eq("ready_before_edge", bus.o_ready, 0);
    @(posedge clk);
    #1;
    check_eq("ready_after_release", bus.o_ready, 1);
    model_clear();
  endtask

  // One cycle per iteration: drive at posedge+1, check and decide at negedge.
  task automatic run(input int gap_pct, input int ready_pct, input int stall_at, input int reset_at);
    int  budget;
    int  words_seen;
    int  stall_left;
    bit  stalled;
    bit  held_v;
    logic [7:0] held_d;
    logic held_l;
    bit  rdy_out;
    bit  vld;
    bit  exp_rdy;
    bit  xfer;
    bit  cons;
    logic [8:0] e;
    budget = 20000; words_seen = 0; stall_left = 0; stalled = 0; held_v = 0;
    held_d = '0; held_l = 0;
    while ((q_bits.size() > 0 || g_full) && budget > 0) begin
      if (stall_left > 0) begin
        rdy_out = 0;
        stall_left--;
      end else begin
        rdy_out = ($urandom_range(99) < ready_pct);
      end
      vld = (q_bits.size() > 0) && ($urandom_range(99) >= gap_pct);
      bus.i_ready_output = rdy_out;
      bus.i_valid_input = vld;
      bus.i_data = vld ? q_bits[0] : 1'($urandom);
      #4;
      check_eq("o_valid", bus.o_valid, g_full);
      if (q_bits.size() > 0) begin
        exp_rdy = !(q_sync[0] && q_done[0] && g_full && !rdy_out);
        check_eq("o_sync", bus.o_sync, q_sync[0]);
        check_eq("o_ready", bus.o_ready, exp_rdy);
        if (!exp_rdy) stall_drops++;
      end
      if (held_v) begin
        check_eq("hold_data", bus.o_data, held_d);
        check_eq("hold_last", bus.o_last, held_l);
      end
      xfer = bus.o_valid && rdy_out;
      if (xfer) begin
        if (q_exp.size() == 0) begin
          check_eq("extra_word", {bus.o_last, bus.o_data}, 32'hDEAD);
        end else begin
          e = q_exp.pop_front();
          check_eq("word_data", bus.o_data, e[7:0]);
          check_eq("word_last", bus.o_last, e[8]);
        end
        words_seen++;
        pkt_words++;
        if (bus.o_last) begin
          check_eq("pkt_len", pkt_words, NWORDS);
          pkt_words = 0;
          n_pkts++;
        end
      end
      held_v = bus.o_valid && !rdy_out;
      held_d = bus.o_data;
      held_l = bus.o_last;
      cons = vld && bus.o_ready;
      if (xfer) g_full = 0;
      if (cons) begin
        if (q_done[0]) g_full = 1;
        void'(q_bits.pop_front());
        void'(q_sync.pop_front());
        void'(q_done.pop_front());
      end
      if (!stalled && stall_at >= 0 && words_seen == stall_at) begin
        stalled = 1;
        stall_left = 20;
      end
      if (reset_at >= 0 && words_seen == reset_at) begin
        do_reset(2);
        return;
      end
      @(posedge clk);
      #1;
      budget--;
    end
    bus.i_valid_input = 1'b0;
    bus.i_ready_output = 1'b1;
    check_eq("run_timeout", budget == 0, 0);
    check_eq("words_missing", q_exp.size(), 0);
  endtask

  initial begin
    bus.i_data = 1'b0;
    bus.i_valid_input = 1'b0;
    bus.i_ready_output = 1'b1;
    n_pkts = 0;
    stall_drops = 0;
    model_clear();
    do_reset(2);

    // Plain packet of 0x81, no gaps, sink always ready.
    push_packet(0);
    run(0, 100, -1, -1);

    // Near-miss sync word, then the real one with random payload and gaps.
    push_word(32'hCF80AA30, 32);
    push_packet(1);
    run(20, 100, -1, -1);

    // Sink stalls for 20 cycles mid-packet.
    stall_drops = 0;
    push_packet(1);
    run(0, 100, 50, -1);
    check_eq("stall_seen", stall_drops > 0, 1);

    // Sync word inside the payload is just data.
    push_packet(2);
    run(10, 100, -1, -1);

    // Reset at word 100, then a fresh packet.
    push_packet(1);
    run(0, 100, -1, 100);
    check_eq("rst_flush", q_exp.size(), 0);
    push_packet(1);
    run(0, 100, -1, -1);

    // Two back-to-back packets, random gaps and random sink backpressure.
    push_packet(1);
    push_packet(1);
    run(30, 70, -1, -1);

    check_eq("pkt_count", n_pkts, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unpack.md
UNPACK -- requirements
Module: unpack

Interface
REQ-001 The block SHALL have parameter SIZE_BIT_PACK, default 1976, meaning payload bits per packet, excluding the preamble.
REQ-002 The block SHALL have parameter SIZE_OUTPUT_BIT, default 8, meaning output word width; SIZE_BIT_PACK SHALL be a multiple of it.
REQ-003 The block SHALL have parameter PREAMBLE, default 32'hCF80AA31, meaning the sync word, sent MSB first.
REQ-004 The block SHALL have parameter SIZE_PREAMBLE, default 32, meaning the preamble length in bits.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port i_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port i_data, input, 1 bit: serial line bit.
REQ-008 The block SHALL have port i_valid_input, input, 1 bit: i_data is valid this cycle.
REQ-009 The block SHALL have port o_ready, output, 1 bit: the block accepts i_data this cycle.
REQ-010 The block SHALL have port o_data, output, SIZE_OUTPUT_BIT bits: the recovered word, first received bit at the MSB.
REQ-011 The block SHALL have port o_valid, output, 1 bit: o_data is valid.
REQ-012 The block SHALL have port i_ready_output, input, 1 bit: the sink accepts o_data.
REQ-013 The block SHALL have port o_last, output, 1 bit: o_data is the final word of the packet.
REQ-014 The block SHALL have port o_sync, output, 1 bit: the preamble is locked and payload is being received.

Function
REQ-015 An input bit SHALL be consumed only on a cycle where i_valid_input=1 and o_ready=1.
REQ-016 An output word SHALL be transferred only on a cycle where o_valid=1 and i_ready_output=1.
REQ-017 The FSM SHALL have exactly two states, SEARCH and RECEIVE.
REQ-018 In SEARCH, o_ready=1, o_sync=0, and each consumed bit SHALL shift into the LSB of a SIZE_PREAMBLE-bit window.
REQ-019 When the window, including the bit consumed this cycle, equals PREAMBLE, the FSM SHALL enter RECEIVE on the next edge, and the bit and word counters SHALL be cleared.
REQ-020 In RECEIVE, o_sync=1, and consumed bits SHALL shift MSB-first into a word shift register.
REQ-021 On consumption of bit SIZE_OUTPUT_BIT-1 of a word, the word SHALL load into the output slot, and o_valid SHALL assert on the next cycle (1-cycle latency).
REQ-022 o_ready in RECEIVE SHALL be 0 only when bit SIZE_OUTPUT_BIT-1 is pending, o_valid=1, and i_ready_output=0; a slot freed in the same cycle SHALL permit the load.
REQ-023 o_data and o_last SHALL hold stable while o_valid=1 and i_ready_output=0.
REQ-024 o_last SHALL be 1 only with word number SIZE_BIT_PACK/SIZE_OUTPUT_BIT-1 (default 246).
REQ-025 After the last word is loaded, the FSM SHALL return to SEARCH on the next edge with the window cleared to zero, so payload bits cannot retrigger a match mid-packet and no overlap with the previous packet is possible.
REQ-026 The block SHALL not search for the preamble during RECEIVE.
REQ-027 Idle cycles (i_valid_input=0) SHALL not advance any counter or the window.
REQ-028 The bit counter SHALL be $clog2(SIZE_OUTPUT_BIT) wide and the word counter $clog2(SIZE_BIT_PACK/SIZE_OUTPUT_BIT) wide.
REQ-029 Neither counter SHALL wrap within a packet.

Reset
REQ-030 While i_reset_n=0, the state SHALL be SEARCH and the window, shift register, counters, o_data, o_valid, o_last, o_sync and o_ready SHALL all be 0.
REQ-031 Reset SHALL take effect immediately, independent of i_clk.
REQ-032 On reset release, o_ready SHALL rise at the first rising edge.
REQ-033 Reset asserted mid-packet SHALL discard the partial packet, and no o_last SHALL be emitted for it.

Structure
REQ-034 A shared package pack_pkg SHALL hold SIZE_BIT_PACK, PREAMBLE, SIZE_PREAMBLE, and the state enum {SEARCH, RECEIVE}, also used by the transmit-side Pack block.
REQ-035 Preamble matching SHALL be one sub-module, preamble_detector, containing the window register with a clear input and a match output.

Verification
REQ-036 Reset, then send preamble CF80AA31 followed by 1976 bits of repeating byte 0x81 with i_ready_output=1: the bench SHALL see 247 words of 0x81, o_last on word 247 only, o_sync high for exactly the payload.
REQ-037 Send CF80AA30, then CF80AA31, then the payload: the bench SHALL see no output for the first word, one full packet for the second, and the data SHALL match.
REQ-038 Hold i_ready_output=0 for 20 cycles mid-packet: o_ready SHALL drop at the 8th bit of the next word, o_data SHALL stay stable, and no bit SHALL be lost.
REQ-039 Send payload containing CF80AA31 at byte 10: the bench SHALL see it emitted as data, and the packet length SHALL remain 247 words.
REQ-040 Assert i_reset_n=0 for 2 cycles at word 100, then send a fresh packet: the bench SHALL see all outputs 0 during reset, then exactly one complete 247-word packet.
REQ-041 Send two back-to-back packets with random i_valid_input gaps: the bench SHALL see both recovered intact, with o_sync low between them.
